// File: rtl/hpu_seq_pkg.sv
// rtl/hpu_seq_pkg.sv - shared states and defaults for the HPU job sequencer
package hpu_seq_pkg;

  localparam int SRC_BEATS_DEF = 512;
  localparam int DST_BEATS_DEF = 32;
  localparam int FRAME_W_DEF   = 16;
  localparam int TO_W_DEF      = 20;
  localparam int MAT_W         = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MATW = 3'd1,
    ST_GAP  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/beat_frame_ctr.sv
// rtl/beat_frame_ctr.sv - beat counter wrapping every BEATS beats, with a saturating frame count
module beat_frame_ctr #(
  parameter int BEATS   = 512,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               beat,
  input  logic               en,
  output logic [FRAME_W-1:0] frames,
  output logic               wrap
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [BW-1:0] beat_cnt;
  logic          hit;

  assign hit  = beat & en;
  assign wrap = hit && (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      frames   <= '0;
    end else if (clr) begin
      beat_cnt <= '0;
      frames   <= '0;
    end else if (hit) begin
      if (wrap) begin
        beat_cnt <= '0;
        if (frames != '1)
          frames <= frames + FRAME_W'(1);
      end else begin
        beat_cnt <= beat_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/hpu_job_seq.sv
// rtl/hpu_job_seq.sv - autonomous matrix-load / source-frame job sequencer with stall watchdog
module hpu_job_seq
  import hpu_seq_pkg::*;
#(
  parameter int SRC_BEATS = SRC_BEATS_DEF,
  parameter int DST_BEATS = DST_BEATS_DEF,
  parameter int FRAME_W   = FRAME_W_DEF,
  parameter int TO_W      = TO_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAT_W-1:0]   cfg_mat_beats,
  input  logic [FRAME_W-1:0] cfg_frames,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               in_valid,
  input  logic               in_ready,
  input  logic               out_valid,
  input  logic               out_ready,
  output logic               matw,
  output logic               run,
  output logic               last,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [FRAME_W-1:0] frames_in,
  output logic [FRAME_W-1:0] frames_out
);

  seq_state_t state, state_nxt;

  logic [MAT_W-1:0]   cfg_mat_q, mat_cnt;
  logic [FRAME_W-1:0] cfg_frames_q, frames_last;
  logic [TO_W-1:0]    cfg_to_q, wd_cnt;
  logic               err_q, in_done;
  logic               in_beat, out_beat, any_beat;
  logic               launch, job_clr;
  logic               mat_last, wd_active, wd_trip, job_end;
  logic               in_en, out_en, in_wrap, out_wrap;

  assign in_beat     = in_valid & in_ready;
  assign out_beat    = out_valid & out_ready;
  assign any_beat    = in_beat | out_beat;
  assign launch      = (state == ST_IDLE) && start;
  assign job_clr     = launch && (cfg_frames != '0);
  assign frames_last = cfg_frames_q - FRAME_W'(1);

  assign mat_last  = in_beat && (mat_cnt == cfg_mat_q - MAT_W'(1));
  assign wd_active = (state == ST_MATW) || (state == ST_RUN);
  assign wd_trip   = wd_active && !any_beat && (cfg_to_q != '0) &&
                     (wd_cnt == cfg_to_q - TO_W'(1));
  assign job_end   = out_wrap && (frames_out == frames_last);

  // Input beats stop counting once the job's last source frame is complete.
  assign in_en  = (state == ST_RUN) && !in_done;
  assign out_en = (state == ST_RUN);

  beat_frame_ctr #(.BEATS(SRC_BEATS), .FRAME_W(FRAME_W)) u_in_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (job_clr),
    .beat   (in_beat),
    .en     (in_en),
    .frames (frames_in),
    .wrap   (in_wrap)
  );

  beat_frame_ctr #(.BEATS(DST_BEATS), .FRAME_W(FRAME_W)) u_out_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (job_clr),
    .beat   (out_beat),
    .en     (out_en),
    .frames (frames_out),
    .wrap   (out_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_frames == '0)
              state_nxt = ST_DONE;
            else if (cfg_mat_beats == '0)
              state_nxt = ST_GAP;
            else
              state_nxt = ST_MATW;
          end
        end
        ST_MATW: begin
          if (mat_last)
            state_nxt = ST_GAP;
          else if (wd_trip)
            state_nxt = ST_ERR;
        end
        ST_GAP:  state_nxt = ST_RUN;
        ST_RUN: begin
          if (job_end)
            state_nxt = ST_DONE;
          else if (wd_trip)
            state_nxt = ST_ERR;
        end
        ST_DONE: state_nxt = ST_IDLE;
        ST_ERR: begin
          if (start)
            state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    matw = 1'b0;
    run  = 1'b0;
    last = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_MATW: begin
        matw = 1'b1;
        busy = 1'b1;
      end
      ST_GAP:  busy = 1'b1;
      ST_RUN: begin
        run  = 1'b1;
        busy = 1'b1;
        last = (frames_in == frames_last);
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_mat_q    <= '0;
      cfg_frames_q <= '0;
      cfg_to_q     <= '0;
      err_q        <= 1'b0;
    end else if (launch) begin
      cfg_mat_q    <= cfg_mat_beats;
      cfg_frames_q <= cfg_frames;
      cfg_to_q     <= cfg_timeout;
      err_q        <= 1'b0;
    end else if (state_nxt == ST_ERR) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mat_cnt <= '0;
    else if (job_clr)
      mat_cnt <= '0;
    else if ((state == ST_MATW) && in_beat && (mat_cnt != '1))
      mat_cnt <= mat_cnt + MAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      in_done <= 1'b0;
    else if (job_clr)
      in_done <= 1'b0;
    else if (in_wrap && (frames_in == frames_last))
      in_done <= 1'b1;
  end

  // Stall counter only runs in the phases that wait on stream traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd_cnt <= '0;
    else if (!wd_active || any_beat)
      wd_cnt <= '0;
    else if (wd_cnt != '1)
      wd_cnt <= wd_cnt + TO_W'(1);
  end

endmodule
